seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle restoring divider for the datapath's DIV instruction: the inverse of the carry-lookahead addition path, producing quotient and remainder through one trial subtraction per cycle. It sits beside the ALU and multiplier. It accepts one operand pair per `start` pulse and returns registered results with a one-cycle `done` pulse. The control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width (≥ 4).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: request a division; sampled only when `busy` = 0.
- `dividend`, in, WIDTH: numerator, captured on the accepting edge.
- `divisor`, in, WIDTH: denominator, captured on the accepting edge.
- `busy`, out, 1: high while an operation is in flight.
- `done`, out, 1: one-cycle pulse; results are valid from this cycle on.
- `quotient`, out, WIDTH: registered quotient, held until the next `done`.
- `remainder`, out, WIDTH: registered remainder, held until the next `done`.
- `div_by_zero`, out, 1: set with `done` when the captured divisor was 0; held with the results.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, `start` = 1 (edge E0):**
  - Capture the operands.
  - Load `rem` = 0, `q` = magnitude(dividend), counter = WIDTH.
  - `busy` goes to 1.
  - Divisor = 0: go directly to FIX with `dbz` set. Otherwise go to CALC.
- **CALC (edges E1..E_WIDTH), one restoring step per edge:**
  - Shift {rem, q} left by 1.
  - trial = shifted_rem − |divisor|, computed at WIDTH+1 bits as shifted_rem + ~|divisor| + 1.
  - trial ≥ 0: rem = trial and q[0] = 1. Otherwise rem is unchanged and q[0] = 0.
  - Decrement the counter. Go to FIX when the counter reaches 1→0.
- **FIX (one edge):**
  - Apply the sign correction (see Configuration).
  - Register `quotient`/`remainder`.
  - Pulse `done` = 1 and drop `busy` = 0 on the same edge.
  - Return to IDLE.
- **Divide by zero:** `quotient` = all ones, `remainder` = original dividend, `div_by_zero` = 1.
- **Handshake rules:**
  - `start` while `busy` = 1 is ignored; the operands are not re-captured.
  - `start` in the `done` cycle is accepted, because `busy` is already 0 (back-to-back operation).
- **Results:** `div_by_zero` is cleared on the next accepted `start`. The result registers keep their old values until the next FIX edge.
- **Reset:** asserting `rst_n` low at any time, including mid-CALC, forces IDLE immediately. The operation is abandoned and no `done` is produced.

## Timing
- Reset values: `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `div_by_zero` = 0, state = IDLE, counter = 0.
- Normal latency: `start` sampled at E0, `done` high after edge E(WIDTH+1) for exactly one cycle. For WIDTH = 32 that is 34 cycles from acceptance.
- Divide-by-zero latency: `done` high after E1 (2 cycles).
- Latency does not depend on operand values or on the configuration macro.
- `busy` is high from after E0 through the cycle before `done`.

## Configuration
- Macro: `SEQ_DIVIDER_SIGNED_EN`.
- **Defined:** operands are two's complement.
  - Magnitudes are taken at capture.
  - In FIX, the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend. Quotient truncates toward zero.
  - Overflow 0x80000000 / 0xFFFFFFFF gives `quotient` = 0x80000000 (natural wrap) and `remainder` = 0.
- **Undefined:** operands are unsigned. FIX passes `q`/`rem` through unchanged but still takes its cycle.

## Test plan
- 100 / 7 (WIDTH = 32) → `done` 34 cycles after `start`, `quotient` = 14, `remainder` = 2, `div_by_zero` = 0.
- 0xFFFFFF9C / 7:
  - Signed build → `quotient` = 0xFFFFFFF2, `remainder` = 0xFFFFFFFE.
  - Unsigned build → `quotient` = 0x24924916, `remainder` = 2.
- 55 / 0 → `done` 2 cycles after `start`, `div_by_zero` = 1, `quotient` = 0xFFFFFFFF, `remainder` = 55.
- Handshake sequence:
  - Start 100/7.
  - Pulse `start` with 9/3 at cycle 10; it must be ignored, and the first result is still 14 r 2.
  - Assert `start` with 9/3 in the `done` cycle → second `done` 34 cycles later with 3 r 0.
- Start 1000/3, assert `rst_n` = 0 at cycle 10 → all outputs 0 at once. After release, `done` never fires for that operation and `busy` = 0.
- Signed build, 0x80000000 / 0xFFFFFFFF → `quotient` = 0x80000000, `remainder` = 0, `div_by_zero` = 0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle restoring divider for the DIV instruction.
//
// One trial subtraction per clock. A start pulse while idle captures the
// operands. Quotient and remainder appear on registered outputs together
// with a one-cycle done pulse. Divide-by-zero takes a short path: it skips
// the iterations and returns all-ones and the original dividend.
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   : two's complement operands (magnitude divide + sign fix-up)
//   undefined : unsigned operands (the fix-up cycle passes results through)
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request; sampled only while busy = 0
//   dividend     in   [WIDTH-1:0] numerator, captured on the accepting edge
//   divisor      in   [WIDTH-1:0] denominator, captured on the accepting edge
//   busy         out  operation in flight
//   done         out  one-cycle pulse; results valid from this cycle on
//   quotient     out  [WIDTH-1:0] held until the next done
//   remainder    out  [WIDTH-1:0] held until the next done
//   div_by_zero  out  captured divisor was zero; held with the results
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(WIDTH);
  localparam logic [WIDTH:0] TRIAL_ONE = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;   // divisor magnitude
  logic [WIDTH-1:0] dvd_reg, dvd_next;   // original dividend, for divide-by-zero
  logic             dbz_reg, dbz_next;
  logic             busy_next, done_next, div_by_zero_next;
  logic [WIDTH-1:0] quotient_next, remainder_next;

  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH:0]   shifted, trial;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
  // The most negative value maps onto itself, which is already its correct
  // unsigned magnitude.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  // The remainder stays below the divisor, so the shifted remainder needs one
  // extra bit. The (WIDTH+1)-bit difference then never overflows, which lets
  // its top bit serve as the borrow.
  assign shifted = {rem_reg, q_reg[WIDTH-1]};
  assign trial   = shifted + ~{1'b0, dvs_reg} + TRIAL_ONE;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    rem_next         = rem_reg;
    q_next           = q_reg;
    dvs_next         = dvs_reg;
    dvd_next         = dvd_reg;
    dbz_next         = dbz_reg;
    busy_next        = busy;
    done_next        = 1'b0;
    div_by_zero_next = div_by_zero;
    quotient_next    = quotient;
    remainder_next   = remainder;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_q_next       = neg_q_reg;
    neg_r_next       = neg_r_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          dvd_next         = dividend;
          dvs_next         = divisor_mag;
          rem_next         = '0;
          q_next           = dividend_mag;
          cnt_next         = CNT_LOAD;
          dbz_next         = (divisor == '0);
          busy_next        = 1'b1;
          div_by_zero_next = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_q_next       = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_next       = dividend[WIDTH-1];
`endif
          state_next       = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        // A borrow means the trial failed: keep the shifted remainder.
        q_next   = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
        rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = FIX;
        end
      end
      FIX: begin
        if (dbz_reg) begin
          quotient_next  = '1;
          remainder_next = dvd_reg;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          quotient_next  = neg_q_reg ? -q_reg : q_reg;
          remainder_next = neg_r_reg ? -rem_reg : rem_reg;
`else
          quotient_next  = q_reg;
          remainder_next = rem_reg;
`endif
        end
        div_by_zero_next = dbz_reg;
        done_next        = 1'b1;
        busy_next        = 1'b0;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      dvd_reg     <= '0;
      dbz_reg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rem_reg     <= rem_next;
      q_reg       <= q_next;
      dvs_reg     <= dvs_next;
      dvd_reg     <= dvd_next;
      dbz_reg     <= dbz_next;
      busy        <= busy_next;
      done        <= done_next;
      div_by_zero <= div_by_zero_next;
      quotient    <= quotient_next;
      remainder   <= remainder_next;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH = 32). Stimulus pushes expected
// results; the monitor pops and compares every done pulse.
// Latency is counted in rising edges from the accepting edge to the edge that
// raises done: WIDTH+1 = 33 normally, 1 for divide-by-zero.
module tb_seq_divider;

  localparam int PERIOD = 10;
  localparam int LAT    = 33;
  localparam int LAT0   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t sb[$];

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [31:0] NEG_Q = 32'hFFFF_FFF2, NEG_R = 32'hFFFF_FFFE;
  localparam logic [31:0] OVF_Q = 32'h8000_0000, OVF_R = 32'h0000_0000;
`else
  localparam logic [31:0] NEG_Q = 32'h2492_4916, NEG_R = 32'h0000_0002;
  localparam logic [31:0] OVF_Q = 32'h0000_0000, OVF_R = 32'h8000_0000;
`endif

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #(PERIOD/2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each done pulse against the oldest expected entry.
  initial begin
    longint t;
    exp_t e;
    forever begin
      @(posedge clk);
      t = $time;
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done");
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
          chk("latency", 32'(int'((t - e.acc) / PERIOD)), 32'(e.lat));
          $display("txn: q=%h r=%h dbz=%0b", quotient, remainder, div_by_zero);
        end
      end
    end
  end

  // Drive one request; if now=0 it starts at the next falling edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edbz, input int elat,
                       input bit push, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat; e.acc = $time;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end else begin
      chk("busy_in_done", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    #(PERIOD*2 + 1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, 1, 0);
    wait_done();
    issue(32'hFFFF_FF9C, 32'd7, NEG_Q, NEG_R, 1'b0, LAT, 1, 0);
    wait_done();
    issue(32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, LAT0, 1, 0);
    wait_done();
    @(negedge clk);
    chk("dbz_held", {31'b0, div_by_zero}, 32'd1);
    issue(32'd7, 32'd9, 32'd0, 32'd7, 1'b0, LAT, 1, 0);
    wait_done();
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, 1, 0);
    wait_done();
    issue(32'h8000_0000, 32'hFFFF_FFFF, OVF_Q, OVF_R, 1'b0, LAT, 1, 0);
    wait_done();

    // Handshake: a start while busy is ignored; a start in the done cycle is taken.
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, 1, 0);
    repeat (9) @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    chk("busy_at_ignored_start", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT, 1, 1);
    wait_done();

    // Reset in the middle of CALC abandons the operation.
    issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, LAT, 0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(PERIOD * 5000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
